// File: rtl/instr_fetch_unit_pkg.sv
// rtl/instr_fetch_unit_pkg.sv - fetch state encoding and default widths shared with the decoder
package instr_fetch_unit_pkg;

    localparam int DEF_ADDR_W = 15;
    localparam int DEF_DATA_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DRAIN = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - instruction fetch FSM, instruction register and PC control
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              run,
    input  logic [ADDR_W-1:0] pc_value,
    output logic              pc_inc,
    output logic              pc_load,
    output logic [ADDR_W-1:0] pc_data,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              instr_valid,
    output logic [DATA_W-1:0] instr_data,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              instr_ready,
    input  logic              branch_req,
    input  logic [ADDR_W-1:0] branch_target
);

    fetch_state_t      state;
    fetch_state_t      state_nx;
    fetch_state_t      resume;
    logic              capture;
    logic [ADDR_W-1:0] addr_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            instr_data <= '0;
            instr_pc   <= '0;
            addr_q     <= '0;
        end else begin
            state <= state_nx;
            if (capture) begin
                instr_data <= mem_rdata;
                instr_pc   <= pc_value;
            end
            // The PC moves to the branch target while a drained request is still
            // outstanding, so the issued address is remembered here.
            if (state == ST_FETCH) begin
                addr_q <= pc_value;
            end
        end
    end

    always_comb begin
        state_nx = state;
        resume   = run ? ST_FETCH : ST_IDLE;
        capture  = 1'b0;
        pc_inc   = 1'b0;
        pc_load  = branch_req;
        pc_data  = branch_req ? branch_target : '0;

        case (state)
            ST_IDLE: begin
                if (!branch_req && run) begin
                    state_nx = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (branch_req) begin
                    state_nx = mem_ack ? resume : ST_DRAIN;
                end else if (mem_ack) begin
                    capture  = 1'b1;
                    pc_inc   = 1'b1;
                    state_nx = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (branch_req || instr_ready) begin
                    state_nx = resume;
                end
            end
            ST_DRAIN: begin
                if (mem_ack) begin
                    state_nx = resume;
                end
            end
        endcase

        // PC strobes must fall with reset even though branch_req is a raw input.
        if (!reset_n) begin
            pc_load = 1'b0;
            pc_inc  = 1'b0;
            pc_data = '0;
        end
    end

    assign mem_req     = (state == ST_FETCH) || (state == ST_DRAIN);
    assign mem_addr    = (state == ST_DRAIN) ? addr_q : pc_value;
    assign instr_valid = (state == ST_HOLD);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - directed vector table plus randomized run against a program-stream model
module tb_instr_fetch_unit;

    localparam int AW = 15;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          run = 1'b0;
    logic [AW-1:0] pc_value;
    logic          pc_inc;
    logic          pc_load;
    logic [AW-1:0] pc_data;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_ack = 1'b0;
    logic [DW-1:0] mem_rdata = '0;
    logic          instr_valid;
    logic [DW-1:0] instr_data;
    logic [AW-1:0] instr_pc;
    logic          instr_ready = 1'b0;
    logic          branch_req = 1'b0;
    logic [AW-1:0] branch_target = '0;

    logic [AW-1:0] pc;

    int checks = 0;
    int failures = 0;

    instr_fetch_unit dut (
        .clk(clk), .reset_n(reset_n), .run(run), .pc_value(pc_value),
        .pc_inc(pc_inc), .pc_load(pc_load), .pc_data(pc_data),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .instr_valid(instr_valid), .instr_data(instr_data), .instr_pc(instr_pc),
        .instr_ready(instr_ready), .branch_req(branch_req), .branch_target(branch_target)
    );

    always #5 clk = ~clk;

    // Program counter that the unit steers.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n)     pc <= '0;
        else if (pc_load) pc <= pc_data;
        else if (pc_inc)  pc <= pc + 1'b1;
    end
    assign pc_value = pc;

    typedef struct {
        logic          run, ack;
        logic [DW-1:0] rdata;
        logic          ready, br;
        logic [AW-1:0] tgt;
        logic          e_req;
        logic [AW-1:0] e_addr;
        logic          e_inc, e_load, e_valid;
        logic [DW-1:0] e_data;
        logic [AW-1:0] e_ipc;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic a, input logic [DW-1:0] d,
                                input logic rdy, input logic b, input logic [AW-1:0] t,
                                input logic eq, input logic [AW-1:0] ea, input logic ei,
                                input logic el, input logic ev, input logic [DW-1:0] ed,
                                input logic [AW-1:0] ep);
        vec_t v;
        v.run = r; v.ack = a; v.rdata = d; v.ready = rdy; v.br = b; v.tgt = t;
        v.e_req = eq; v.e_addr = ea; v.e_inc = ei; v.e_load = el;
        v.e_valid = ev; v.e_data = ed; v.e_ipc = ep;
        return v;
    endfunction

    function automatic logic [DW-1:0] word_at(input logic [AW-1:0] a);
        return {1'b0, a} ^ 16'h5A3C;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Random-phase scoreboard state
    bit            outst;
    bit            doomed;
    int            lat;
    logic [AW-1:0] held;
    logic [AW-1:0] exp_next;
    bit            prev_hold;
    logic [DW-1:0] prev_data;
    logic [AW-1:0] prev_pc;
    int            deliveries;
    logic          ack_now;

    initial begin
        //            run ack rdata    rdy br tgt      | req addr     inc ld vld data     ipc
        vecs.push_back(mk(1, 0, 16'h0000, 0, 0, 15'h0000, 0, 15'h0000, 0, 0, 0, 16'h0000, 15'h0000));
        vecs.push_back(mk(1, 1, 16'hA001, 0, 0, 15'h0000, 1, 15'h0000, 1, 0, 0, 16'h0000, 15'h0000));
        vecs.push_back(mk(1, 0, 16'h0000, 1, 0, 15'h0000, 0, 15'h0000, 0, 0, 1, 16'hA001, 15'h0000));
        vecs.push_back(mk(1, 1, 16'hA002, 0, 0, 15'h0000, 1, 15'h0001, 1, 0, 0, 16'h0000, 15'h0000));
        vecs.push_back(mk(0, 0, 16'h0000, 1, 0, 15'h0000, 0, 15'h0000, 0, 0, 1, 16'hA002, 15'h0001));
        vecs.push_back(mk(0, 0, 16'h0000, 0, 1, 15'h0005, 0, 15'h0000, 0, 1, 0, 16'h0000, 15'h0000));
        vecs.push_back(mk(1, 0, 16'h0000, 0, 0, 15'h0000, 0, 15'h0000, 0, 0, 0, 16'h0000, 15'h0000));
        vecs.push_back(mk(1, 0, 16'h0000, 0, 0, 15'h0000, 1, 15'h0005, 0, 0, 0, 16'h0000, 15'h0000));
        vecs.push_back(mk(1, 0, 16'h0000, 0, 0, 15'h0000, 1, 15'h0005, 0, 0, 0, 16'h0000, 15'h0000));
        vecs.push_back(mk(1, 0, 16'h0000, 0, 0, 15'h0000, 1, 15'h0005, 0, 0, 0, 16'h0000, 15'h0000));
        vecs.push_back(mk(1, 1, 16'hB005, 0, 0, 15'h0000, 1, 15'h0005, 1, 0, 0, 16'h0000, 15'h0000));
        vecs.push_back(mk(1, 0, 16'h0000, 0, 0, 15'h0000, 0, 15'h0000, 0, 0, 1, 16'hB005, 15'h0005));
        vecs.push_back(mk(1, 0, 16'h0000, 0, 0, 15'h0000, 0, 15'h0000, 0, 0, 1, 16'hB005, 15'h0005));
        vecs.push_back(mk(1, 0, 16'h0000, 0, 0, 15'h0000, 0, 15'h0000, 0, 0, 1, 16'hB005, 15'h0005));
        vecs.push_back(mk(1, 0, 16'h0000, 1, 0, 15'h0000, 0, 15'h0000, 0, 0, 1, 16'hB005, 15'h0005));
        vecs.push_back(mk(1, 0, 16'h0000, 0, 1, 15'h0100, 1, 15'h0006, 0, 1, 0, 16'h0000, 15'h0000));
        vecs.push_back(mk(1, 0, 16'h0000, 0, 0, 15'h0000, 1, 15'h0006, 0, 0, 0, 16'h0000, 15'h0000));
        vecs.push_back(mk(1, 1, 16'hDEAD, 0, 0, 15'h0000, 1, 15'h0006, 0, 0, 0, 16'h0000, 15'h0000));
        vecs.push_back(mk(1, 1, 16'hC100, 0, 1, 15'h0200, 1, 15'h0100, 0, 1, 0, 16'h0000, 15'h0000));
        vecs.push_back(mk(1, 1, 16'hC200, 0, 0, 15'h0000, 1, 15'h0200, 1, 0, 0, 16'h0000, 15'h0000));
        vecs.push_back(mk(1, 0, 16'h0000, 1, 1, 15'h0300, 0, 15'h0000, 0, 1, 1, 16'hC200, 15'h0200));
        vecs.push_back(mk(1, 0, 16'h0000, 0, 0, 15'h0000, 1, 15'h0300, 0, 0, 0, 16'h0000, 15'h0000));
        vecs.push_back(mk(1, 1, 16'hC300, 0, 0, 15'h0000, 1, 15'h0300, 1, 0, 0, 16'h0000, 15'h0000));
        vecs.push_back(mk(1, 0, 16'h0000, 0, 1, 15'h0010, 0, 15'h0000, 0, 1, 1, 16'hC300, 15'h0300));
        vecs.push_back(mk(1, 0, 16'h0000, 0, 0, 15'h0000, 1, 15'h0010, 0, 0, 0, 16'h0000, 15'h0000));

        repeat (2) @(posedge clk);
        #1;
        chk("reset_mem_req", {31'd0, mem_req}, 32'd0);
        chk("reset_instr_valid", {31'd0, instr_valid}, 32'd0);
        chk("reset_instr_data", {16'd0, instr_data}, 32'd0);
        chk("reset_instr_pc", {17'd0, instr_pc}, 32'd0);
        chk("reset_pc_data", {17'd0, pc_data}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            run = vecs[i].run; mem_ack = vecs[i].ack; mem_rdata = vecs[i].rdata;
            instr_ready = vecs[i].ready; branch_req = vecs[i].br; branch_target = vecs[i].tgt;
            #1;
            chk($sformatf("row%0d_mem_req", i), {31'd0, mem_req}, {31'd0, vecs[i].e_req});
            chk($sformatf("row%0d_pc_inc", i), {31'd0, pc_inc}, {31'd0, vecs[i].e_inc});
            chk($sformatf("row%0d_pc_load", i), {31'd0, pc_load}, {31'd0, vecs[i].e_load});
            chk($sformatf("row%0d_instr_valid", i), {31'd0, instr_valid}, {31'd0, vecs[i].e_valid});
            if (vecs[i].e_req)
                chk($sformatf("row%0d_mem_addr", i), {17'd0, mem_addr}, {17'd0, vecs[i].e_addr});
            if (vecs[i].e_load)
                chk($sformatf("row%0d_pc_data", i), {17'd0, pc_data}, {17'd0, vecs[i].tgt});
            if (vecs[i].e_valid) begin
                chk($sformatf("row%0d_instr_data", i), {16'd0, instr_data}, {16'd0, vecs[i].e_data});
                chk($sformatf("row%0d_instr_pc", i), {17'd0, instr_pc}, {17'd0, vecs[i].e_ipc});
            end
        end

        // Asynchronous reset while a request is outstanding and a branch is pending
        #2;
        branch_req = 1'b1; mem_ack = 1'b1;
        reset_n = 1'b0;
        #1;
        chk("async_rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("async_rst_instr_valid", {31'd0, instr_valid}, 32'd0);
        chk("async_rst_pc_inc", {31'd0, pc_inc}, 32'd0);
        chk("async_rst_pc_load", {31'd0, pc_load}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1; run = 1'b1; branch_req = 1'b0; mem_ack = 1'b0; instr_ready = 1'b0;
        #1;
        chk("restart_idle_req", {31'd0, mem_req}, 32'd0);
        @(negedge clk);
        #1;
        chk("restart_req", {31'd0, mem_req}, 32'd1);
        chk("restart_addr", {17'd0, mem_addr}, 32'd0);

        // Randomized run: memory with random latency, random ready/run/branches
        outst = 0; doomed = 0; lat = 0; held = '0; exp_next = '0;
        prev_hold = 0; prev_data = '0; prev_pc = '0; deliveries = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (mem_req && !outst) begin
                outst = 1; doomed = 0; held = mem_addr; lat = $urandom_range(0, 3);
            end
            ack_now = outst && (lat == 0);
            if (outst && lat != 0) lat--;
            mem_ack = ack_now;
            mem_rdata = word_at(held);
            run = ($urandom_range(0, 7) != 0);
            instr_ready = ($urandom_range(0, 2) != 0);
            branch_req = ($urandom_range(0, 9) == 0);
            branch_target = ($urandom_range(0, 3) == 0) ? 15'h7FFE : AW'($urandom);
            #1;
            if (outst) begin
                chk("rnd_req_held", {31'd0, mem_req}, 32'd1);
                chk("rnd_addr_stable", {17'd0, mem_addr}, {17'd0, held});
                if (!doomed) chk("rnd_addr_is_pc", {17'd0, mem_addr}, {17'd0, pc});
            end
            chk("rnd_pc_inc", {31'd0, pc_inc}, {31'd0, ack_now && !doomed && !branch_req});
            chk("rnd_pc_load", {31'd0, pc_load}, {31'd0, branch_req});
            if (branch_req) chk("rnd_pc_data", {17'd0, pc_data}, {17'd0, branch_target});
            if (prev_hold) begin
                chk("rnd_valid_kept", {31'd0, instr_valid}, 32'd1);
                chk("rnd_data_stable", {16'd0, instr_data}, {16'd0, prev_data});
                chk("rnd_ipc_stable", {17'd0, instr_pc}, {17'd0, prev_pc});
            end
            if (instr_valid && instr_ready) begin
                chk("rnd_deliver_pc", {17'd0, instr_pc}, {17'd0, exp_next});
                chk("rnd_deliver_data", {16'd0, instr_data}, {16'd0, word_at(instr_pc)});
                exp_next = instr_pc + 1'b1;
                deliveries++;
            end
            if (branch_req) begin
                exp_next = branch_target;
                if (outst) doomed = 1;
            end
            prev_hold = instr_valid && !instr_ready && !branch_req;
            prev_data = instr_data;
            prev_pc = instr_pc;
            if (ack_now) outst = 0;
        end
        chk("rnd_progress", {31'd0, deliveries > 100}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
